// File: rtl/timer_alarm_scheduler_pkg.sv
// Shared types and helpers for the timer alarm scheduler.
// Deadlines are absolute 64-bit timer values; delays are 32-bit tick counts.
package timer_sched_pkg;

  localparam int MAX_REQ  = 16;
  localparam int DELAY_W  = 32;
  localparam int TIME_W   = 64;

  typedef logic [TIME_W-1:0]  deadline_t;
  typedef logic [DELAY_W-1:0] delay_t;

  // Wrap-safe "now is at or past dl": valid while the distance stays below 2^63.
  function automatic logic expired(input deadline_t now, input deadline_t dl);
    deadline_t diff;
    diff = now - dl;
    return ~diff[TIME_W-1];
  endfunction

  // Signed distance to the deadline; negative once the deadline has passed.
  function automatic deadline_t remaining(input deadline_t now, input deadline_t dl);
    return dl - now;
  endfunction

endpackage

// File: rtl/timer_alarm_scheduler_if.sv
// Requester-side bundle of the alarm scheduler: arm handshake, cancel and status.
// master = requesters, slave = scheduler.
interface timer_alarm_scheduler_if
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DELAY_W-1:0] req_delay;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         cancel;
  logic [NUM_REQ-1:0]         fire;
  logic [NUM_REQ-1:0]         armed;
  logic                       busy;

  modport master (
    output req_valid, req_delay, cancel,
    input  req_ready, fire, armed, busy
  );

  modport slave (
    input  req_valid, req_delay, cancel,
    output req_ready, fire, armed, busy
  );
endinterface

// File: rtl/timer_alarm_scheduler_rr_arb.sv
// Round-robin arbiter: the registered pointer holds the first index to search,
// advanced to last grant + 1 (mod N) whenever a grant is issued.
module timer_sched_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;

  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_valid) begin
      ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Per-requester relative-timeout alarms on a shared 64-bit timer, one slot scanned per cycle.
// Optional TIMER_SCHED_NEXT_EN adds a registered earliest-deadline output for TIMER_CMP.
module timer_alarm_scheduler
  import timer_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  deadline_t                     timer_val_i,
  timer_alarm_scheduler_if.slave        bus
`ifdef TIMER_SCHED_NEXT_EN
  ,
  output logic                          next_valid_o,
  output deadline_t                     next_deadline_o
`endif
);

  logic [NUM_REQ-1:0] armed_reg;
  logic [NUM_REQ-1:0] armed_next;
  deadline_t          deadline_reg  [NUM_REQ];
  deadline_t          deadline_next [NUM_REQ];
  delay_t             delay_arr     [NUM_REQ];
  logic [IDX_W-1:0]   scan_ptr_reg;
  logic [IDX_W-1:0]   scan_ptr_next;
  logic [NUM_REQ-1:0] fire_reg;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               hit;
  logic [NUM_REQ-1:0] hit_vec;
  deadline_t          new_deadline;

  timer_sched_rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .req       (eligible),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // A single adder serves every slot since at most one request is granted per cycle.
  assign new_deadline = timer_val_i + {{(TIME_W-DELAY_W){1'b0}}, delay_arr[gnt_idx]};

  // Cancel on the scanned slot suppresses the expiry detected in the same cycle.
  assign hit = armed_reg[scan_ptr_reg] & ~bus.cancel[scan_ptr_reg]
             & expired(timer_val_i, deadline_reg[scan_ptr_reg]);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign delay_arr[gi]     = bus.req_delay[gi*DELAY_W +: DELAY_W];
    assign eligible[gi]      = ~rst_i & bus.req_valid[gi] & ~armed_reg[gi] & ~bus.cancel[gi];
    assign hit_vec[gi]       = hit & (scan_ptr_reg == IDX_W'(gi));
    assign armed_next[gi]    = gnt[gi] | (armed_reg[gi] & ~bus.cancel[gi] & ~hit_vec[gi]);
    assign deadline_next[gi] = (gnt_valid && (gnt_idx == IDX_W'(gi))) ? new_deadline
                                                                       : deadline_reg[gi];
  end

  assign scan_ptr_next = (scan_ptr_reg == IDX_W'(NUM_REQ - 1)) ? '0 : scan_ptr_reg + IDX_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_reg    <= '0;
      scan_ptr_reg <= '0;
      fire_reg     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        deadline_reg[i] <= '0;
      end
    end else begin
      armed_reg    <= armed_next;
      scan_ptr_reg <= scan_ptr_next;
      fire_reg     <= hit_vec;
      for (int i = 0; i < NUM_REQ; i++) begin
        deadline_reg[i] <= deadline_next[i];
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.fire      = fire_reg;
  assign bus.armed     = armed_reg;
  assign bus.busy      = |armed_reg;

`ifdef TIMER_SCHED_NEXT_EN
  logic      min_found;
  deadline_t min_rem;
  deadline_t min_dl;
  deadline_t rem;
  logic      next_valid_reg;
  deadline_t next_deadline_reg;

  // Smallest signed remaining time wins; strict compare keeps the lowest index on ties.
  always_comb begin
    min_found = 1'b0;
    min_rem   = '0;
    min_dl    = '0;
    rem       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem = remaining(timer_val_i, deadline_reg[i]);
      if (armed_reg[i] && (!min_found || ($signed(rem) < $signed(min_rem)))) begin
        min_found = 1'b1;
        min_rem   = rem;
        min_dl    = deadline_reg[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      next_valid_reg    <= 1'b0;
      next_deadline_reg <= '0;
    end else begin
      next_valid_reg    <= min_found;
      next_deadline_reg <= min_dl;
    end
  end

  assign next_valid_o    = next_valid_reg;
  assign next_deadline_o = next_deadline_reg;
`endif

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Directed bench for timer_alarm_scheduler: a scoreboard of expected fires (slot, deadline)
// is filled at acceptance and emptied as fire pulses appear inside the latency window.
module tb_timer_alarm_scheduler;
  import timer_sched_pkg::*;

  localparam int N = 4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  deadline_t timer_val = '0;

  timer_alarm_scheduler_if #(.NUM_REQ(N)) bus_if ();

`ifdef TIMER_SCHED_NEXT_EN
  logic      next_valid;
  deadline_t next_deadline;
`endif

  timer_alarm_scheduler #(.NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .timer_val_i (timer_val),
    .bus         (bus_if)
`ifdef TIMER_SCHED_NEXT_EN
    ,
    .next_valid_o    (next_valid),
    .next_deadline_o (next_deadline)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] slot;
    deadline_t   dl;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  logic [N-1:0] pend_valid = '0;
  logic [N-1:0] cancel_v = '0;
  logic [31:0] pend_delay [N];
  logic        rst_cmd = 1'b1;
  logic        load_pending = 1'b0;
  deadline_t   load_val = '0;
  int          sc_cur = 0;
  logic        last_rst = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // fire is registered, so at the falling edge timer_val still holds the detect-cycle value.
  task automatic check_fires();
    int        hit_idx;
    deadline_t diff;
    if (bus_if.fire != '0) begin
      chk("fire_onehot", 64'($countones(bus_if.fire)), 64'd1);
    end
    for (int i = 0; i < N; i++) begin
      if (bus_if.fire[i]) begin
        hit_idx = -1;
        foreach (sb[j]) begin
          if (hit_idx < 0 && sb[j].slot == 32'(i)) hit_idx = j;
        end
        chk($sformatf("fire_expected_slot%0d", i), 64'(hit_idx >= 0), 64'd1);
        if (hit_idx >= 0) begin
          diff = timer_val - sb[hit_idx].dl;
          chk($sformatf("fire_window_slot%0d", i), 64'(diff < 64'(N)), 64'd1);
          sb.delete(hit_idx);
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, then record accepted requests.
  task automatic step();
    @(negedge clk);
    check_fires();
    timer_val    = load_pending ? load_val : timer_val + 64'd1;
    load_pending = 1'b0;
    rst          = rst_cmd;
    sc_cur       = (last_rst || rst) ? 0 : (sc_cur + 1) % N;
    last_rst     = rst;
    bus_if.req_valid = pend_valid;
    bus_if.cancel    = cancel_v;
    for (int i = 0; i < N; i++) begin
      bus_if.req_delay[i*32 +: 32] = pend_delay[i];
    end
    #1;
    if (bus_if.req_ready != '0) begin
      chk("ready_onehot_valid", 64'(($countones(bus_if.req_ready) == 1) &&
          ((bus_if.req_ready & ~bus_if.req_valid) == '0)), 64'd1);
    end
    for (int i = 0; i < N; i++) begin
      if (bus_if.req_valid[i] && bus_if.req_ready[i]) begin
        sb.push_back('{slot: 32'(i), dl: timer_val + 64'(pend_delay[i])});
        grant_log.push_back(i);
        pend_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input deadline_t t0);
    pend_valid = '0;
    cancel_v   = '0;
    sb.delete();
    grant_log.delete();
    load_val     = t0;
    load_pending = 1'b1;
    rst_cmd      = 1'b1;
    step();
    rst_cmd = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    repeat (N + 2) step();
  endtask

  task automatic arm(input int i, input deadline_t target);
    pend_delay[i] = 32'(target - (timer_val + 64'd1));
    pend_valid[i] = 1'b1;
    step();
    chk($sformatf("arm_accept_slot%0d", i), 64'(pend_valid[i]), 64'd0);
  endtask

  initial begin
    deadline_t dl4;
    int        guard;
    int        nxt_sc;

    bus_if.req_valid = '0;
    bus_if.req_delay = '0;
    bus_if.cancel    = '0;
    for (int i = 0; i < N; i++) pend_delay[i] = 32'd0;

    // Reset state, with every requester asking during reset.
    pend_valid = '1;
    rst_cmd    = 1'b1;
    step();
    chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
    chk("rst_armed", 64'(bus_if.armed), 64'd0);
    chk("rst_busy",  64'(bus_if.busy), 64'd0);
    chk("rst_fire",  64'(bus_if.fire), 64'd0);
    pend_valid = '0;

    // Delay and fire timing.
    do_reset(64'd99);
    pend_valid[0] = 1'b1;
    pend_delay[0] = 32'd10;
    step();
    chk("t1_accept", 64'(pend_valid[0]), 64'd0);
    step();
    chk("t1_armed", 64'(bus_if.armed[0]), 64'd1);
    chk("t1_busy",  64'(bus_if.busy), 64'd1);
    drain("t1", 50);
    chk("t1_disarmed", 64'(bus_if.armed), 64'd0);

    // Simultaneous arbitration, two bursts.
    for (int burst = 0; burst < 2; burst++) begin
      if (burst == 0) do_reset(64'd300);
      grant_log.delete();
      pend_valid = '1;
      for (int i = 0; i < N; i++) pend_delay[i] = 32'(5 + i);
      repeat (N) step();
      chk("t2_grant_count", 64'(grant_log.size()), 64'(N));
      for (int k = 0; k < N; k++) begin
        chk($sformatf("t2_burst%0d_grant%0d", burst, k),
            64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(k));
      end
      drain($sformatf("t2_burst%0d", burst), 60);
    end

    // Wrap-around of the timer.
    do_reset(64'hFFFF_FFFF_FFFF_FFEF);
    pend_valid[0] = 1'b1;
    pend_delay[0] = 32'd32;
    step();
    chk("t3_accept", 64'(pend_valid[0]), 64'd0);
    chk("t3_deadline", (sb.size() == 1) ? sb[0].dl : 64'hDEAD, 64'h10);
    drain("t3", 80);

    // Cancel racing expiry on slot 2.
    do_reset(64'd1000);
    pend_valid[2] = 1'b1;
    pend_delay[2] = 32'd20;
    step();
    chk("t4_accept", 64'(pend_valid[2]), 64'd0);
    dl4   = 64'd1021;
    guard = 0;
    nxt_sc = (sc_cur + 1) % N;
    while (!(expired(timer_val + 64'd1, dl4) && nxt_sc == 2) && guard < 200) begin
      step();
      guard++;
      nxt_sc = (sc_cur + 1) % N;
    end
    chk("t4_aligned", 64'(guard < 200), 64'd1);
    chk("t4_armed_before", 64'(bus_if.armed[2]), 64'd1);
    cancel_v[2] = 1'b1;
    sb.delete();
    step();
    cancel_v[2] = 1'b0;
    step();
    chk("t4_armed_after", 64'(bus_if.armed[2]), 64'd0);
    repeat (N + 4) step();
    chk("t4_busy", 64'(bus_if.busy), 64'd0);

    // Reset mid-operation.
    do_reset(64'd2000);
    pend_valid = 4'b0111;
    for (int i = 0; i < N; i++) pend_delay[i] = 32'd50;
    repeat (4) step();
    chk("t5_armed_pre", 64'(bus_if.armed), 64'h7);
    sb.delete();
    rst_cmd = 1'b1;
    step();
    chk("t5_armed_rst", 64'(bus_if.armed), 64'd0);
    chk("t5_busy_rst",  64'(bus_if.busy), 64'd0);
    rst_cmd = 1'b0;
    repeat (100) step();
    chk("t5_armed_end", 64'(bus_if.armed), 64'd0);

`ifdef TIMER_SCHED_NEXT_EN
    // Earliest-deadline output.
    do_reset(64'd100);
    arm(0, 64'd500);
    arm(1, 64'd300);
    arm(3, 64'd300);
    repeat (2) step();
    chk("t6_valid_a", 64'(next_valid), 64'd1);
    chk("t6_dl_a", next_deadline, 64'd300);
    guard = 0;
    while (sb.size() > 1 && guard < 400) begin
      step();
      guard++;
    end
    repeat (2) step();
    chk("t6_valid_b", 64'(next_valid), 64'd1);
    chk("t6_dl_b", next_deadline, 64'd500);
    drain("t6", 300);
    repeat (2) step();
    chk("t6_valid_c", 64'(next_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
